// File: rtl/rs_issue_scheduler.sv
// Reservation-station scheduler: lowest-free allocation, age-matrix oldest-ready select, registered issue.
// Optional RS_SCHED_PERF_EN adds saturating issue/stall/full performance counters.
module rs_issue_scheduler #(
  parameter int NUM_RS = 8,
  parameter int IDX_W  = $clog2(NUM_RS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              branch_mispredict,
  input  logic [NUM_RS-1:0] busy_rs,
  input  logic [NUM_RS-1:0] ready_rs,
  input  logic              alloc_req,
  output logic              alloc_gnt,
  output logic [IDX_W-1:0]  alloc_idx,
  output logic [NUM_RS-1:0] rs_we,
  output logic              rs_full,
  output logic              iss_valid,
  output logic [IDX_W-1:0]  iss_idx,
  input  logic              iss_ready,
  output logic [NUM_RS-1:0] rs_to_free
`ifdef RS_SCHED_PERF_EN
  ,
  output logic [31:0]       perf_issue_cnt,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_full_cnt
`endif
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;
  localparam logic [NUM_RS-1:0] ONE = {{(NUM_RS-1){1'b0}}, 1'b1};

  logic [0:0]        state;
  logic [NUM_RS-1:0] age [NUM_RS];
  logic [NUM_RS-1:0] iss_oh;
  logic [NUM_RS-1:0] cand;
  logic [NUM_RS-1:0] oldest;
  logic [IDX_W-1:0]  sel_idx;
  logic              any_cand;
  logic              fire;

  assign iss_valid = (state == HOLD);
  assign iss_oh    = ONE << iss_idx;

  // Descending scan so the lowest free index is the last one written.
  always_comb begin
    alloc_idx = '0;
    for (int i = NUM_RS - 1; i >= 0; i--) begin
      if (!busy_rs[i]) alloc_idx = IDX_W'(i);
    end
  end

  assign rs_full    = &busy_rs;
  assign alloc_gnt  = alloc_req & ~rs_full & ~branch_mispredict;
  assign rs_we      = alloc_gnt ? (ONE << alloc_idx) : '0;
  assign fire       = iss_valid & iss_ready & ~branch_mispredict;
  assign rs_to_free = fire ? iss_oh : '0;

  // The entry already held on the issue port is not a candidate for reselection.
  assign cand     = busy_rs & ready_rs & ~(iss_valid ? iss_oh : '0);
  assign any_cand = |cand;

  always_comb begin
    for (int i = 0; i < NUM_RS; i++) begin
      oldest[i] = cand[i];
      for (int j = 0; j < NUM_RS; j++) begin
        if (j != i && cand[j] && !age[i][j]) oldest[i] = 1'b0;
      end
    end
  end

  // Lowest-index candidate is the fallback when no unique oldest exists.
  always_comb begin
    sel_idx = '0;
    for (int i = NUM_RS - 1; i >= 0; i--) begin
      if (cand[i]) sel_idx = IDX_W'(i);
    end
    for (int i = NUM_RS - 1; i >= 0; i--) begin
      if (oldest[i]) sel_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_RS; i++) age[i] <= '0;
    end else if (branch_mispredict) begin
      for (int i = 0; i < NUM_RS; i++) age[i] <= '0;
    end else if (alloc_gnt) begin
      for (int j = 0; j < NUM_RS; j++) begin
        if (j == int'(alloc_idx)) age[j] <= '0;
        else                      age[j][alloc_idx] <= busy_rs[j];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      iss_idx <= '0;
    end else if (branch_mispredict) begin
      state <= IDLE;
    end else if (state == IDLE || fire) begin
      state <= any_cand ? HOLD : IDLE;
      if (any_cand) iss_idx <= sel_idx;
    end
  end

`ifdef RS_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
      perf_full_cnt  <= '0;
    end else begin
      if (fire && perf_issue_cnt != 32'hFFFF_FFFF) perf_issue_cnt <= perf_issue_cnt + 32'd1;
      if (iss_valid && !iss_ready && perf_stall_cnt != 32'hFFFF_FFFF)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (alloc_req && rs_full && perf_full_cnt != 32'hFFFF_FFFF)
        perf_full_cnt <= perf_full_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Directed bench for rs_issue_scheduler; the bench plays the RS array and scoreboards issued indices.
module tb_rs_issue_scheduler;
  logic       clk = 1'b0;
  logic       rst_n, branch_mispredict, alloc_req, iss_ready;
  logic [7:0] busy_rs, ready_rs;
  logic       alloc_gnt, rs_full, iss_valid;
  logic [2:0] alloc_idx, iss_idx;
  logic [7:0] rs_we, rs_to_free;
`ifdef RS_SCHED_PERF_EN
  logic [31:0] perf_issue_cnt, perf_stall_cnt, perf_full_cnt;
`endif

  int ntests = 0;
  int nfail  = 0;
  int m_issue = 0, m_stall = 0, m_full = 0;
  int q[$];

  always #5 clk = ~clk;

  rs_issue_scheduler #(.NUM_RS(8)) dut (
    .clk(clk), .rst_n(rst_n), .branch_mispredict(branch_mispredict),
    .busy_rs(busy_rs), .ready_rs(ready_rs), .alloc_req(alloc_req),
    .alloc_gnt(alloc_gnt), .alloc_idx(alloc_idx), .rs_we(rs_we), .rs_full(rs_full),
    .iss_valid(iss_valid), .iss_idx(iss_idx), .iss_ready(iss_ready), .rs_to_free(rs_to_free)
`ifdef RS_SCHED_PERF_EN
    , .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt), .perf_full_cnt(perf_full_cnt)
`endif
  );

  function automatic logic [7:0] oh(input int i);
    logic [7:0] one;
    one = 8'b1;
    return one << i;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check any fire against the scoreboard, then advance the RS-array model.
  task automatic cyc();
    logic [7:0] nb;
    int e;
    if (iss_valid && iss_ready && !branch_mispredict) begin
      ntests++;
      assert (q.size() > 0) else begin
        nfail++;
        $error("FAIL unexpected_fire: observed idx %0d expected no issue", iss_idx);
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("fire_idx", 32'(iss_idx), 32'(e));
        chk("fire_free", 32'(rs_to_free), 32'(oh(e)));
      end
      m_issue++;
    end else begin
      chk("no_free", 32'(rs_to_free), 32'h0);
    end
    if (iss_valid && !iss_ready) m_stall++;
    if (alloc_req && (&busy_rs)) m_full++;
    nb = branch_mispredict ? 8'h00 : ((busy_rs | rs_we) & ~rs_to_free);
    @(posedge clk);
    #1;
    busy_rs  = nb;
    ready_rs = ready_rs & nb;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; branch_mispredict = 1'b0; alloc_req = 1'b0; iss_ready = 1'b0;
    busy_rs = 8'h00; ready_rs = 8'h00;
    #1;
    chk("rst_valid", 32'(iss_valid), 32'h0);
    chk("rst_idx", 32'(iss_idx), 32'h0);
    chk("rst_free", 32'(rs_to_free), 32'h0);
    chk("rst_alloc_idx", 32'(alloc_idx), 32'h0);
    chk("rst_full", 32'(rs_full), 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Allocation order 3,0,5 using preset busy bits, then all ready together.
    busy_rs = 8'h07; alloc_req = 1'b1; #1;
    chk("a3_gnt", 32'(alloc_gnt), 32'h1);
    chk("a3_idx", 32'(alloc_idx), 32'h3);
    chk("a3_we", 32'(rs_we), 32'h08);
    cyc();
    busy_rs = 8'h0E; #1;
    chk("a0_idx", 32'(alloc_idx), 32'h0);
    chk("a0_we", 32'(rs_we), 32'h01);
    cyc();
    busy_rs = 8'h1F; #1;
    chk("a5_idx", 32'(alloc_idx), 32'h5);
    cyc();
    alloc_req = 1'b0; busy_rs = 8'h29; ready_rs = 8'h29; iss_ready = 1'b1;
    q.push_back(3); q.push_back(0); q.push_back(5);
    #1;
    chk("ord_lat0", 32'(iss_valid), 32'h0);
    cyc();
    chk("ord_v3", 32'(iss_valid), 32'h1);
    chk("ord_i3", 32'(iss_idx), 32'h3);
    cyc();
    chk("ord_i0", 32'(iss_idx), 32'h0);
    cyc();
    chk("ord_i5", 32'(iss_idx), 32'h5);
    cyc();
    chk("ord_done", 32'(iss_valid), 32'h0);

    // Backpressure: held idx stays put while a younger entry becomes ready.
    alloc_req = 1'b1; iss_ready = 1'b0; #1;
    chk("bp_a0", 32'(alloc_idx), 32'h0);
    cyc();
    chk("bp_a1", 32'(alloc_idx), 32'h1);
    cyc();
    alloc_req = 1'b0; ready_rs = 8'h01; q.push_back(0); #1;
    cyc();
    chk("bp_v", 32'(iss_valid), 32'h1);
    ready_rs = 8'h03; q.push_back(1); #1;
    for (int k = 0; k < 4; k++) begin
      chk("bp_hold_idx", 32'(iss_idx), 32'h0);
      chk("bp_hold_v", 32'(iss_valid), 32'h1);
      cyc();
    end
    iss_ready = 1'b1; #1;
    chk("bp_free0", 32'(rs_to_free), 32'h01);
    cyc();
    chk("bp_v1", 32'(iss_valid), 32'h1);
    chk("bp_i1", 32'(iss_idx), 32'h1);
    cyc();
    chk("bp_done", 32'(iss_valid), 32'h0);

    // Full array; a fire of entry 2 makes it allocatable next cycle.
    busy_rs = 8'hFF; ready_rs = 8'h04; alloc_req = 1'b1; iss_ready = 1'b0; q.push_back(2); #1;
    chk("full_gnt", 32'(alloc_gnt), 32'h0);
    chk("full_flag", 32'(rs_full), 32'h1);
    chk("full_we", 32'(rs_we), 32'h0);
    cyc();
    chk("full_i2", 32'(iss_idx), 32'h2);
    iss_ready = 1'b1; #1;
    chk("full_gnt_fire", 32'(alloc_gnt), 32'h0);
    chk("full_free2", 32'(rs_to_free), 32'h04);
    cyc();
    chk("refill_gnt", 32'(alloc_gnt), 32'h1);
    chk("refill_idx", 32'(alloc_idx), 32'h2);
    chk("refill_full", 32'(rs_full), 32'h0);
    chk("refill_we", 32'(rs_we), 32'h04);
    chk("refill_idle", 32'(iss_valid), 32'h0);
    cyc();
    alloc_req = 1'b0; iss_ready = 1'b0; busy_rs = 8'h00; ready_rs = 8'h00; #1;

    // Flush with a held issue, FU ready and an allocation request.
    alloc_req = 1'b1; #1;
    cyc(); cyc();
    alloc_req = 1'b0; ready_rs = 8'h03; #1;
    cyc();
    chk("fl_v", 32'(iss_valid), 32'h1);
    chk("fl_i0", 32'(iss_idx), 32'h0);
    branch_mispredict = 1'b1; alloc_req = 1'b1; iss_ready = 1'b1; #1;
    chk("fl_free", 32'(rs_to_free), 32'h0);
    chk("fl_gnt", 32'(alloc_gnt), 32'h0);
    chk("fl_we", 32'(rs_we), 32'h0);
    cyc();
    branch_mispredict = 1'b0; #1;
    chk("fl_idle", 32'(iss_valid), 32'h0);
    chk("fl_a0", 32'(alloc_idx), 32'h0);
    chk("fl_gnt0", 32'(alloc_gnt), 32'h1);
    cyc();
    chk("fl_a1", 32'(alloc_idx), 32'h1);
    cyc();
    alloc_req = 1'b0; ready_rs = 8'h03; q.push_back(0); q.push_back(1); #1;
    cyc();
    chk("fl_new_i0", 32'(iss_idx), 32'h0);
    cyc();
    chk("fl_new_i1", 32'(iss_idx), 32'h1);
    cyc();
    chk("fl_new_done", 32'(iss_valid), 32'h0);
    iss_ready = 1'b0;

`ifdef RS_SCHED_PERF_EN
    chk("perf_issue", perf_issue_cnt, 32'(m_issue));
    chk("perf_stall", perf_stall_cnt, 32'(m_stall));
    chk("perf_full", perf_full_cnt, 32'(m_full));
`endif

    // Asynchronous reset while holding a non-zero index.
    busy_rs = 8'h08; ready_rs = 8'h08; #1;
    cyc();
    chk("ar_v", 32'(iss_valid), 32'h1);
    chk("ar_i3", 32'(iss_idx), 32'h3);
    rst_n = 1'b0; #1;
    chk("ar_valid0", 32'(iss_valid), 32'h0);
    chk("ar_idx0", 32'(iss_idx), 32'h0);
    chk("sb_empty", 32'(q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
